// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and derived widths.
package shift_add_mul_pkg;

   localparam int N_DEF  = 5;
   localparam int PW_DEF = 2 * N_DEF;
   localparam int CW_DEF = $clog2(N_DEF) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      ADD  = 2'b10,
      DONE = 2'b11
   } state_t;

   // Step counter must hold the value N itself, hence one bit beyond clog2.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/shift_add_mul_ctrl.sv
// Controller for shift_add_mul: FSM sequencing IDLE/CALC/ADD/DONE plus the step down-counter.
module shift_add_mul_ctrl
   import shift_add_mul_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic Start,
   output logic load,
   output logic shift,
   output logic final_add,
   output logic Ready,
   output logic Done
);

   localparam int CW = cnt_width(N);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;

   // NOTE: state registers use non-blocking assignments; the combinational block below uses blocking ones.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (load)
            cnt <= CW'(N);
         else if (shift)
            cnt <= cnt - CW'(1);
      end
   end

   // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_nx  = state;
      load      = 1'b0;
      shift     = 1'b0;
      final_add = 1'b0;
      Ready     = 1'b0;
      Done      = 1'b0;
      case (state)
         IDLE: begin
            Ready = 1'b1;
            if (Start) begin
               load     = 1'b1;
               state_nx = CALC;
            end
         end
         CALC: begin
            shift = 1'b1;
            if (cnt == CW'(1))
               state_nx = ADD;
         end
         ADD: begin
            final_add = 1'b1;
            state_nx  = DONE;
         end
         DONE: begin
            Done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential shift-and-add multiplier: Product = A*B + AddIn after N CALC steps and one ADD step.
module shift_add_mul
   import shift_add_mul_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic [N-1:0]     A,
   input  logic [N-1:0]     B,
   input  logic [N-1:0]     AddIn,
   output logic [2*N-1:0]   Product,
   output logic             Ready,
   output logic             Done
);

   localparam int PW = 2 * N;

   logic           load, shift, final_add;
   logic [N:0]     hi;
   logic [N-1:0]   lo;
   logic [N-1:0]   a_q;
   logic [N-1:0]   add_q;
   logic [N:0]     sum_hi;

   shift_add_mul_ctrl #(.N(N)) u_ctrl (
      .CLK       (CLK),
      .RST       (RST),
      .Start     (Start),
      .load      (load),
      .shift     (shift),
      .final_add (final_add),
      .Ready     (Ready),
      .Done      (Done)
   );

   // hi keeps a carry bit so the partial sum never truncates before the shift.
   assign sum_hi = lo[0] ? (hi + {1'b0, a_q}) : hi;

   // NOTE: every datapath register is reset, so an aborted operation leaves no stale state behind.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hi      <= '0;
         lo      <= '0;
         a_q     <= '0;
         add_q   <= '0;
         Product <= '0;
      end else begin
         if (load) begin
            hi    <= '0;
            lo    <= B;
            a_q   <= A;
            add_q <= AddIn;
         end else if (shift) begin
            hi <= {1'b0, sum_hi[N:1]};
            lo <= {sum_hi[0], lo[N-1:1]};
         end
         if (final_add)
            Product <= {hi[N-1:0], lo} + PW'(add_q);
      end
   end

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul: directed cases plus randomized operations vs. an arithmetic model.
module tb_shift_add_mul;

   localparam int N  = 5;
   localparam int PW = 2 * N;
   localparam int LAT = N + 1;

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic            Start = 1'b0;
   logic [N-1:0]    A = '0;
   logic [N-1:0]    B = '0;
   logic [N-1:0]    AddIn = '0;
   logic [PW-1:0]   Product;
   logic            Ready;
   logic            Done;

   int n_checks = 0;
   int n_fail   = 0;

   shift_add_mul #(.N(N)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .Start   (Start),
      .A       (A),
      .B       (B),
      .AddIn   (AddIn),
      .Product (Product),
      .Ready   (Ready),
      .Done    (Done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint ref_model(input int a, input int b, input int c);
      return longint'(a) * longint'(b) + longint'(c);
   endfunction

   // Runs one operation from IDLE; inputs are driven #1 after an edge, outputs sampled there too.
   // With scramble set, inputs and Start are randomized every busy cycle.
   task automatic do_op(input int a, input int b, input int c, input bit scramble, input string tag);
      int     edges;
      bit     seen;
      longint exp;
      exp   = ref_model(a, b, c);
      A     = N'(a);
      B     = N'(b);
      AddIn = N'(c);
      Start = 1'b1;
      @(posedge CLK);
      #1;
      Start = 1'b0;
      check({tag, "_ready_busy"}, Ready, 0);
      edges = 0;
      seen  = 0;
      while (!seen && edges < 3 * LAT) begin
         if (scramble) begin
            A     = N'($urandom);
            B     = N'($urandom);
            AddIn = N'($urandom);
            Start = 1'($urandom);
         end
         @(posedge CLK);
         #1;
         edges++;
         if (Done) begin
            seen  = 1;
            Start = 1'b0;
         end else if (Ready) begin
            check({tag, "_ready_early"}, Ready, 0);
         end
      end
      check({tag, "_latency"}, edges, LAT);
      check({tag, "_product"}, Product, exp);
      check({tag, "_ready_in_done"}, Ready, 0);
      @(posedge CLK);
      #1;
      check({tag, "_ready_after"}, Ready, 1);
      check({tag, "_done_one_cycle"}, Done, 0);
      check({tag, "_product_hold"}, Product, exp);
   endtask

   initial begin
      int     dones;
      int     gap;
      longint exp;

      // Reset state
      RST = 1'b0;
      #12;
      check("rst_product", Product, 0);
      check("rst_ready", Ready, 1);
      check("rst_done", Done, 0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;

      do_op(13, 11, 4, 0, "basic");
      do_op(31, 31, 30, 0, "max");
      do_op(25, 0, 7, 0, "b_zero");
      do_op(6, 7, 2, 1, "scramble");

      // Exactly one Done for the scrambled operation: nothing further appears while idle.
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK);
         #1;
         if (Done) dones++;
      end
      check("scramble_extra_done", dones, 0);

      // Abort mid-operation: reset lands just before the 3rd CALC edge.
      A = 5'd9; B = 5'd9; AddIn = 5'd9; Start = 1'b1;
      @(posedge CLK);
      #1;
      Start = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #2;
      RST = 1'b0;
      #1;
      check("abort_product", Product, 0);
      check("abort_ready", Ready, 1);
      check("abort_done", Done, 0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         #1;
         if (Done) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_product_idle", Product, 0);
      do_op(3, 5, 1, 0, "after_abort");

      // Start held high: second operation accepted on the first IDLE edge.
      A = 5'd2; B = 5'd3; AddIn = 5'd0; Start = 1'b1;
      gap = 0;
      dones = 0;
      for (int i = 0; i < 40 && dones < 2; i++) begin
         @(posedge CLK);
         #1;
         if (dones == 1) gap++;
         if (Ready && dones == 1) begin
            A = 5'd4; B = 5'd4; AddIn = 5'd1;
         end
         if (Done) begin
            dones++;
            if (dones == 1) check("b2b_first", Product, 6);
            else            check("b2b_second", Product, 17);
         end else if (dones == 1) begin
            check("b2b_hold", Product, 6);
         end
      end
      Start = 1'b0;
      check("b2b_count", dones, 2);
      check("b2b_spacing", gap, N + 3);
      @(posedge CLK);
      @(posedge CLK);
      #1;

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 25; i++) begin
         int ra, rb, rc;
         ra = int'($urandom_range(31, 0));
         rb = int'($urandom_range(31, 0));
         rc = int'($urandom_range(31, 0));
         do_op(ra, rb, rc, 1'($urandom), $sformatf("rand%0d", i));
         exp = ref_model(ra, rb, rc);
         repeat (int'($urandom_range(2, 0))) @(posedge CLK);
         #1;
         check($sformatf("rand%0d_idle_hold", i), Product, exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/shift_add_mul.md
Name: shift_add_mul

Overview:
- Sequential shift-and-add multiplier with an addend: computes Product = A*B + AddIn over n+2 clock edges.
- Performs the inverse of the restoring divider. Fed quotient, divisor and remainder, it rebuilds the dividend.
- Used for self-check of divider results and as the general multiply unit in the same datapath.
- Start/Ready/Done handshake; all inputs are captured at start.

Parameters:
- N, 5, width of A, B and AddIn; Product is 2N bits.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  reset, asynchronous, active-low (0 = reset).
- Start  input  1  request; sampled only while Ready=1.
- A  input  N  multiplicand (divisor), unsigned.
- B  input  N  multiplier (quotient), unsigned.
- AddIn  input  N  addend (remainder), unsigned.
- Product  output  2N  registered result A*B+AddIn.
- Ready  output  1  high only in IDLE.
- Done  output  1  one-cycle pulse; Product is valid from this cycle.

Behaviour:
- Reset (RST=0, any time including mid-operation):
  - state=IDLE, Product=0, Ready=1, Done=0.
  - Internal accumulator, multiplier register and step counter cleared.
  - The operation in progress is abandoned. No Done pulse for it.
- States: IDLE, CALC, ADD, DONE.
- IDLE:
  - Ready=1.
  - On an edge with Start=1: latch A, AddIn; accumulator hi (N+1 bits)=0; lo (N bits)=B; counter=N; go to CALC.
  - With Start=0: stay in IDLE.
- CALC (Ready=0), each edge:
  - If lo[0]=1: hi=hi+A (N+1-bit add, carry kept in hi[N]).
  - Then {hi,lo} = {hi,lo} >> 1, with 0 shifted into the MSB.
  - counter decrements.
  - The edge where counter==1 moves to ADD, so exactly N CALC edges occur.
- ADD:
  - On the edge: Product = {hi[N-1:0],lo} + zero-extended AddIn, computed 2N bits wide.
  - No overflow is possible: max (2^N-1)^2 + 2^N-1 = 2^2N - 2^N.
  - Go to DONE.
- DONE:
  - Done=1 for exactly one cycle; Ready=0.
  - Next edge returns to IDLE unconditionally.
- Latency: if Start is sampled at edge E0, Product updates and Done rises at edge E(N+1). For N=5, that is 6 edges.
- Ready returns high at E(N+2).
- Product holds its last value until the next ADD edge or reset. It is not cleared on Done.
- Start while Ready=0 is ignored. No queuing.
- Start held continuously: a new operation is accepted on the first edge in IDLE. Back-to-back throughput is one result per N+3 edges.
- A/B/AddIn changes after the Start edge do not affect the current result.
- B=0: still runs N CALC edges; Product=AddIn. Latency is fixed and data-independent.
- Counter width: clog2(N)+1 bits. It never wraps because it is reloaded only in IDLE.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, CALC=2'b01, ADD=2'b10, DONE=2'b11;
  - default N;
  - derived widths PW=2N and CW=clog2(N)+1.
- Controller and datapath split is natural. Sub-module shift_add_mul_ctrl contains the FSM and the step down-counter. It drives load/shift/add/final-add enables plus Ready and Done.
- The top level contains the datapath registers and adders.

Test Plan:
- Reset, then A=13, B=11, AddIn=4, Start pulse for one cycle:
  - Done pulses at the 6th edge after Start is sampled; Product=147 (0x093).
  - Ready=0 throughout, then 1 on the following edge.
- Maximum operands, A=31, B=31, AddIn=30 -> Product=991 (0x3DF). No truncation; carry into hi[N] is exercised.
- A=25, B=0, AddIn=7 -> Product=7, with the same 6-edge latency.
- Pulse Start and change A/B/AddIn every cycle while busy (A=6, B=7, AddIn=2 at start):
  - Product=44.
  - Extra Start pulses during CALC are ignored: exactly one Done.
- Assert RST low during the 3rd CALC edge, release, then start A=3, B=5, AddIn=1:
  - Immediately on reset: Product=0, Ready=1, Done=0; no Done pulse for the aborted operation.
  - New operation gives Product=16.
- Hold Start=1 continuously with A=2, B=3, AddIn=0, then A=4, B=4, AddIn=1 presented when Ready next rises:
  - Results 6 then 17.
  - Done pulses spaced exactly 8 edges apart.
  - Product holds 6 between the two Done pulses.
